// File: rtl/iobus_pkg.sv
// Register map, CTRL/STATUS bit positions and the CTRL register layout
// shared by the IO bus responder and its timer.
package iobus_pkg;
    // Word offsets, decoded from IOBUS_ADDR[5:2]
    localparam logic [3:0] OFS_SW     = 4'h0;
    localparam logic [3:0] OFS_LED    = 4'h1;
    localparam logic [3:0] OFS_CTRL   = 4'h2;
    localparam logic [3:0] OFS_LOAD   = 4'h3;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h5;

    localparam int CTRL_TMR_EN      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_TMR_IRQ_EN  = 2;
    localparam int CTRL_BTN_IRQ_EN  = 3;

    localparam int STAT_TMR = 0;
    localparam int STAT_BTN = 1;

    typedef struct packed {
        logic btnIrqEn;
        logic tmrIrqEn;
        logic autoReload;
        logic tmrEn;
    } ctrl_t;
endpackage

// File: rtl/io_timer.sv
// Prescaled 32-bit down counter with optional auto-reload; pulses expire
// on the tick that finds COUNT at zero.
module io_timer
    import iobus_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  ctrl_t       ctrl,
    input  logic        ctrlWr,
    input  logic        loadWr,
    input  logic        countWr,
    input  logic [31:0] wrData,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic        expire
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] preCnt;
    logic          tick;

    assign tick   = ctrl.tmrEn && (preCnt == PW'(PRESCALE - 1));
    // A software COUNT write on a tick cycle pre-empts that tick entirely
    assign expire = tick && !countWr && (count == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            preCnt <= '0;
            load   <= '0;
            count  <= '0;
        end else begin
            if (!ctrl.tmrEn || tick || (ctrlWr && wrData[CTRL_TMR_EN]))
                preCnt <= '0;
            else
                preCnt <= preCnt + 1'b1;

            if (loadWr)
                load <= wrData;

            if (countWr)
                count <= wrData;
            else if (tick) begin
                if (count != '0)
                    count <= count - 32'd1;
                else if (ctrl.autoReload)
                    count <= load;
            end
        end
    end
endmodule

// File: rtl/iobus_responder.sv
// OTTER IOBUS peripheral: switches, LEDs, timer and button interrupt source.
// Define IOBUS_BTN_DEBOUNCE_EN to insert a debouncer after the BTN synchronizer.
module iobus_responder
    import iobus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1100_0000,
    parameter int          PRESCALE        = 1,
    parameter int          SW_W            = 16,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [31:0]     IOBUS_ADDR,
    input  logic [31:0]     IOBUS_OUT,
    input  logic            IOBUS_WR,
    output logic [31:0]     IOBUS_IN,
    output logic            INTR,
    input  logic [SW_W-1:0] SWITCHES,
    input  logic            BTN,
    output logic [SW_W-1:0] LEDS
);
    logic            hit, wrHit;
    logic [3:0]      ofs;
    logic [SW_W-1:0] swS1, swS2, ledReg;
    logic            btnS1, btnS2, btnSig, btnPrev, btnEdge;
    logic [2:0]      armCnt;
    logic            btnArmed;
    ctrl_t           ctrl;
    logic            tmrFlag, btnFlag, intr;
    logic [31:0]     load, count;
    logic            tmrExpire;

    assign hit      = (IOBUS_ADDR[31:6] == BASE_ADDR[31:6]);
    assign ofs      = IOBUS_ADDR[5:2];
    assign wrHit    = IOBUS_WR && hit;
    assign LEDS     = ledReg;
    assign INTR     = intr;
    // Edges are ignored until the sync/debounce pipeline holds post-reset samples
    assign btnArmed = (armCnt == 3'd4);
    assign btnEdge  = btnArmed && btnSig && !btnPrev;

    io_timer #(.PRESCALE(PRESCALE)) uTimer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ctrl    (ctrl),
        .ctrlWr  (wrHit && ofs == OFS_CTRL),
        .loadWr  (wrHit && ofs == OFS_LOAD),
        .countWr (wrHit && ofs == OFS_COUNT),
        .wrData  (IOBUS_OUT),
        .load    (load),
        .count   (count),
        .expire  (tmrExpire)
    );

`ifdef IOBUS_BTN_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] dbCnt;
    logic           btnDb;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dbCnt <= '0;
            btnDb <= 1'b0;
        end else if (!btnArmed) begin
            btnDb <= btnS2;
            dbCnt <= '0;
        end else if (btnS2 != btnDb) begin
            if (dbCnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btnDb <= btnS2;
                dbCnt <= '0;
            end else
                dbCnt <= dbCnt + 1'b1;
        end else
            dbCnt <= '0;
    end
    assign btnSig = btnDb;
`else
    logic unusedDbCfg;
    assign unusedDbCfg = ^DEBOUNCE_CYCLES;
    assign btnSig      = btnS2;
`endif

    logic unusedAddrLsb;
    assign unusedAddrLsb = ^IOBUS_ADDR[1:0];

    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (ofs)
                OFS_SW:     IOBUS_IN = 32'(swS2);
                OFS_LED:    IOBUS_IN = 32'(ledReg);
                OFS_CTRL:   IOBUS_IN = 32'(ctrl);
                OFS_LOAD:   IOBUS_IN = load;
                OFS_COUNT:  IOBUS_IN = count;
                OFS_STATUS: IOBUS_IN = {30'd0, btnFlag, tmrFlag};
                default:    IOBUS_IN = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            swS1    <= '0;
            swS2    <= '0;
            btnS1   <= 1'b0;
            btnS2   <= 1'b0;
            btnPrev <= 1'b0;
            armCnt  <= '0;
            ledReg  <= '0;
            ctrl    <= '0;
            tmrFlag <= 1'b0;
            btnFlag <= 1'b0;
            intr    <= 1'b0;
        end else begin
            swS1    <= SWITCHES;
            swS2    <= swS1;
            btnS1   <= BTN;
            btnS2   <= btnS1;
            btnPrev <= btnSig;
            if (!btnArmed)
                armCnt <= armCnt + 3'd1;

            if (wrHit && ofs == OFS_LED)
                ledReg <= IOBUS_OUT[SW_W-1:0];

            if (wrHit && ofs == OFS_CTRL) begin
                ctrl.tmrEn      <= IOBUS_OUT[CTRL_TMR_EN];
                ctrl.autoReload <= IOBUS_OUT[CTRL_AUTO_RELOAD];
                ctrl.tmrIrqEn   <= IOBUS_OUT[CTRL_TMR_IRQ_EN];
                ctrl.btnIrqEn   <= IOBUS_OUT[CTRL_BTN_IRQ_EN];
            end else if (tmrExpire && !ctrl.autoReload)
                ctrl.tmrEn <= 1'b0;

            // New events win over a simultaneous write-1-to-clear
            tmrFlag <= tmrExpire || (tmrFlag && !(wrHit && ofs == OFS_STATUS && IOBUS_OUT[STAT_TMR]));
            btnFlag <= btnEdge || (btnFlag && !(wrHit && ofs == OFS_STATUS && IOBUS_OUT[STAT_BTN]));

            intr <= (tmrFlag && ctrl.tmrIrqEn) || (btnFlag && ctrl.btnIrqEn);
        end
    end
endmodule
